seg7_frame_driver: RTL and testbench

- Downstream consumer of the digit scan counter in the 8-digit seven-segment display path.
- Holds a double-buffered 32-bit hex display value with per-digit enable and decimal-point masks.
- Turns the scan's 3-bit digit index into active-low anode and segment drives.
- Adds tear-free frame-boundary commit, anti-ghosting blanking between digits, and optional leading-zero suppression.

---
 rtl/seg7_frame_driver_pkg.sv | 14 +
 rtl/seg7_frame_driver_hex_to_seg7.sv | 13 +
 rtl/seg7_frame_driver.sv | 131 +++++++++++++
 tb/tb_seg7_frame_driver.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_frame_driver_pkg.sv
// Shared constants and the active-low hex segment table for the 8-digit display path.
package seg7_frame_driver_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic [7:0]  ANODE_OFF  = 8'hFF;

  // Entry n is the gfedcba pattern (0 = segment lit) for hex digit n.
  localparam logic [15:0][6:0] HEX_SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg7_frame_driver_hex_to_seg7.sv
// Combinational hex nibble to active-low gfedcba segment decoder.
module hex_to_seg7
  import seg7_frame_driver_pkg::*;
(
  input  logic [3:0] i_nibble,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = HEX_SEG_TABLE[i_nibble];
  end

endmodule

// File: rtl/seg7_frame_driver.sv
// Double-buffered 8-digit seven-segment frame driver with frame-boundary commit,
// inter-digit blanking and optional leading-zero suppression.
module seg7_frame_driver
  import seg7_frame_driver_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  digit_index,
  input  logic        load,
  input  logic [31:0] value_in,
  input  logic [7:0]  en_in,
  input  logic [7:0]  dp_in,
  input  logic        lz_en,
  output logic        commit_pending,
  output logic [7:0]  anode,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam logic [7:0] BLANK_INIT = 8'(BLANK_CYCLES);

  logic [31:0] r_shadow_val, r_act_val;
  logic [7:0]  r_shadow_en, r_shadow_dp, r_act_en, r_act_dp;
  logic        r_pending;
  logic [2:0]  r_digit_q;
  logic [7:0]  r_blank;
  logic [7:0]  r_anode;
  logic [6:0]  r_seg;
  logic        r_dp;

  logic        w_boundary;
  logic [31:0] w_act_val_nxt;
  logic [7:0]  w_act_en_nxt, w_act_dp_nxt;
  logic        w_pending_nxt;
  logic [7:0]  w_blank_nxt;
  logic [3:0]  w_nibble;
  logic [6:0]  w_seg_dec;
  logic        w_upper_zero;
  logic        w_visible;
  logic [7:0]  w_anode_nxt;
  logic [6:0]  w_seg_nxt;
  logic        w_dp_nxt;

  hex_to_seg7 u_hex_to_seg7 (
    .i_nibble (w_nibble),
    .o_seg    (w_seg_dec)
  );

  always_comb begin
    w_boundary    = (r_digit_q == 3'd7) && (digit_index == 3'd0);
    w_act_val_nxt = r_act_val;
    w_act_en_nxt  = r_act_en;
    w_act_dp_nxt  = r_act_dp;
    w_pending_nxt = r_pending;
    // A load landing on the boundary bypasses the shadow so it shows this frame.
    if (w_boundary && load) begin
      w_act_val_nxt = value_in;
      w_act_en_nxt  = en_in;
      w_act_dp_nxt  = dp_in;
      w_pending_nxt = 1'b0;
    end else if (w_boundary && r_pending) begin
      w_act_val_nxt = r_shadow_val;
      w_act_en_nxt  = r_shadow_en;
      w_act_dp_nxt  = r_shadow_dp;
      w_pending_nxt = 1'b0;
    end else if (load) begin
      w_pending_nxt = 1'b1;
    end

    if (digit_index != r_digit_q) begin
      w_blank_nxt = BLANK_INIT;
    end else if (r_blank != 8'd0) begin
      w_blank_nxt = r_blank - 8'd1;
    end else begin
      w_blank_nxt = 8'd0;
    end

    // Outputs use the post-commit buffer so the first digit of a frame is never stale.
    w_nibble     = w_act_val_nxt[{digit_index, 2'b00} +: 4];
    w_upper_zero = (w_act_val_nxt >> {digit_index, 2'b00}) == 32'd0;
    w_visible    = w_act_en_nxt[digit_index] &&
                   !(lz_en && (digit_index != 3'd0) && w_upper_zero);

    w_anode_nxt = ANODE_OFF;
    if ((w_blank_nxt == 8'd0) && w_visible) begin
      w_anode_nxt[digit_index] = 1'b0;
    end
    w_seg_nxt = w_visible ? w_seg_dec : SEG_OFF;
    w_dp_nxt  = w_visible ? ~w_act_dp_nxt[digit_index] : 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow_val <= '0;
      r_shadow_en  <= '0;
      r_shadow_dp  <= '0;
      r_act_val    <= '0;
      r_act_en     <= '0;
      r_act_dp     <= '0;
      r_pending    <= 1'b0;
      r_digit_q    <= '0;
      r_blank      <= '0;
      r_anode      <= ANODE_OFF;
      r_seg        <= SEG_OFF;
      r_dp         <= 1'b1;
    end else begin
      if (load) begin
        r_shadow_val <= value_in;
        r_shadow_en  <= en_in;
        r_shadow_dp  <= dp_in;
      end
      r_act_val <= w_act_val_nxt;
      r_act_en  <= w_act_en_nxt;
      r_act_dp  <= w_act_dp_nxt;
      r_pending <= w_pending_nxt;
      r_digit_q <= digit_index;
      r_blank   <= w_blank_nxt;
      r_anode   <= w_anode_nxt;
      r_seg     <= w_seg_nxt;
      r_dp      <= w_dp_nxt;
    end
  end

  assign commit_pending = r_pending;
  assign anode          = r_anode;
  assign seg            = r_seg;
  assign dp             = r_dp;

endmodule

// File: tb/tb_seg7_frame_driver.sv
// Bench for seg7_frame_driver: directed vector table, blanking sequences, async reset
// and randomized scanning against a behavioural display model.
module tb_seg7_frame_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  digit_index = 3'd0;
  logic        load = 1'b0;
  logic [31:0] value_in = '0;
  logic [7:0]  en_in = '0;
  logic [7:0]  dp_in = '0;
  logic        lz_en = 1'b0;

  logic        pend0, pend1;
  logic [7:0]  anode0, anode1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;

  seg7_frame_driver #(.BLANK_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .digit_index(digit_index), .load(load), .value_in(value_in),
    .en_in(en_in), .dp_in(dp_in), .lz_en(lz_en), .commit_pending(pend0),
    .anode(anode0), .seg(seg0), .dp(dp0)
  );

  seg7_frame_driver #(.BLANK_CYCLES(4)) u_dut1 (
    .clk(clk), .rst(rst), .digit_index(digit_index), .load(load), .value_in(value_in),
    .en_in(en_in), .dp_in(dp_in), .lz_en(lz_en), .commit_pending(pend1),
    .anode(anode1), .seg(seg1), .dp(dp1)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [6:0] ref_seg [16];

  // Behavioural model state
  logic [31:0] m_sh_val, m_act_val;
  logic [7:0]  m_sh_en, m_sh_dp, m_act_en, m_act_dp;
  logic        m_pend;
  int          m_prev, m_di, m_bl0, m_bl1;
  logic        m_lz;

  typedef struct {
    logic [2:0]  di;
    logic        ld;
    logic [31:0] val;
    logic [7:0]  en;
    logic [7:0]  dpm;
    logic        lz;
    logic [7:0]  anode;
    logic [6:0]  seg;
    logic        dp;
    logic        pend;
  } vec_t;

  vec_t vecs [30];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_sh_val = '0; m_sh_en = '0; m_sh_dp = '0;
    m_act_val = '0; m_act_en = '0; m_act_dp = '0;
    m_pend = 1'b0; m_prev = 0; m_di = 0; m_bl0 = 0; m_bl1 = 0; m_lz = 1'b0;
  endtask

  task automatic model_step();
    bit bnd;
    bnd = (m_prev == 7) && (digit_index == 3'd0);
    if (load) begin
      m_sh_val = value_in; m_sh_en = en_in; m_sh_dp = dp_in; m_pend = 1'b1;
    end
    if (bnd && m_pend) begin
      m_act_val = m_sh_val; m_act_en = m_sh_en; m_act_dp = m_sh_dp; m_pend = 1'b0;
    end
    if (int'(digit_index) != m_prev) begin
      m_bl0 = 0; m_bl1 = 4;
    end else begin
      if (m_bl0 > 0) m_bl0--;
      if (m_bl1 > 0) m_bl1--;
    end
    m_prev = int'(digit_index);
    m_di   = int'(digit_index);
    m_lz   = lz_en;
  endtask

  task automatic model_out(input int bl, output logic [7:0] a, output logic [6:0] s,
                           output logic d);
    bit vis;
    logic [31:0] upper;
    upper = m_act_val >> (4 * m_di);
    vis = m_act_en[m_di] && !(m_lz && m_di != 0 && upper == 0);
    a = 8'hFF;
    if (bl == 0 && vis) a[m_di] = 1'b0;
    s = vis ? ref_seg[upper[3:0]] : 7'h7F;
    d = vis ? ~m_act_dp[m_di] : 1'b1;
  endtask

  task automatic check_model();
    logic [7:0] a;
    logic [6:0] s;
    logic d;
    chk("pend0", 32'(pend0), 32'(m_pend));
    chk("pend1", 32'(pend1), 32'(m_pend));
    model_out(m_bl0, a, s, d);
    chk("anode0", 32'(anode0), 32'(a));
    chk("seg0", 32'(seg0), 32'(s));
    chk("dp0", 32'(dp0), 32'(d));
    model_out(m_bl1, a, s, d);
    chk("anode1", 32'(anode1), 32'(a));
    chk("seg1", 32'(seg1), 32'(s));
    chk("dp1", 32'(dp1), 32'(d));
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
    load = 1'b0;
    check_model();
  endtask

  task automatic check_dark(input string tag);
    chk({tag, "_pend0"}, 32'(pend0), 32'd0);
    chk({tag, "_pend1"}, 32'(pend1), 32'd0);
    chk({tag, "_anode0"}, 32'(anode0), 32'hFF);
    chk({tag, "_anode1"}, 32'(anode1), 32'hFF);
    chk({tag, "_seg0"}, 32'(seg0), 32'h7F);
    chk({tag, "_dp0"}, 32'(dp0), 32'd1);
  endtask

  initial begin
    ref_seg = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    //          di    ld    value         en     dp     lz    anode  seg    dp    pend
    vecs[0]  = '{3'd3, 1'b1, 32'h0000_00A5, 8'hFF, 8'h00, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[1]  = '{3'd4, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[2]  = '{3'd5, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[3]  = '{3'd6, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[4]  = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[5]  = '{3'd0, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFE, 7'h12, 1'b1, 1'b0};
    vecs[6]  = '{3'd1, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFD, 7'h08, 1'b1, 1'b0};
    vecs[7]  = '{3'd2, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFB, 7'h40, 1'b1, 1'b0};
    vecs[8]  = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'h7F, 7'h40, 1'b1, 1'b0};
    vecs[9]  = '{3'd0, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFE, 7'h12, 1'b1, 1'b0};
    vecs[10] = '{3'd2, 1'b0, 32'h0,         8'h00, 8'h00, 1'b1, 8'hFF, 7'h7F, 1'b1, 1'b0};
    vecs[11] = '{3'd1, 1'b0, 32'h0,         8'h00, 8'h00, 1'b1, 8'hFD, 7'h08, 1'b1, 1'b0};
    vecs[12] = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b1, 8'hFF, 7'h7F, 1'b1, 1'b0};
    vecs[13] = '{3'd3, 1'b1, 32'h0,         8'hFF, 8'h00, 1'b1, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[14] = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b1, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[15] = '{3'd0, 1'b0, 32'h0,         8'h00, 8'h00, 1'b1, 8'hFE, 7'h40, 1'b1, 1'b0};
    vecs[16] = '{3'd1, 1'b0, 32'h0,         8'h00, 8'h00, 1'b1, 8'hFF, 7'h7F, 1'b1, 1'b0};
    vecs[17] = '{3'd3, 1'b1, 32'h8888_8888, 8'hF0, 8'h01, 1'b0, 8'hF7, 7'h40, 1'b1, 1'b1};
    vecs[18] = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'h7F, 7'h40, 1'b1, 1'b1};
    vecs[19] = '{3'd0, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b0};
    vecs[20] = '{3'd4, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hEF, 7'h00, 1'b1, 1'b0};
    vecs[21] = '{3'd3, 1'b1, 32'h8888_8888, 8'hFF, 8'h01, 1'b0, 8'hFF, 7'h7F, 1'b1, 1'b1};
    vecs[22] = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'h7F, 7'h00, 1'b1, 1'b1};
    vecs[23] = '{3'd0, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFE, 7'h00, 1'b0, 1'b0};
    vecs[24] = '{3'd7, 1'b1, 32'h1111_1111, 8'hFF, 8'h00, 1'b0, 8'h7F, 7'h00, 1'b1, 1'b1};
    vecs[25] = '{3'd0, 1'b1, 32'h2222_2222, 8'hFF, 8'h00, 1'b0, 8'hFE, 7'h24, 1'b1, 1'b0};
    vecs[26] = '{3'd3, 1'b1, 32'h3333_3333, 8'hFF, 8'h00, 1'b0, 8'hF7, 7'h24, 1'b1, 1'b1};
    vecs[27] = '{3'd4, 1'b1, 32'h4444_4444, 8'hFF, 8'h00, 1'b0, 8'hEF, 7'h24, 1'b1, 1'b1};
    vecs[28] = '{3'd7, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'h7F, 7'h24, 1'b1, 1'b1};
    vecs[29] = '{3'd0, 1'b0, 32'h0,         8'h00, 8'h00, 1'b0, 8'hFE, 7'h19, 1'b1, 1'b0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_dark("reset");
    rst = 1'b0;

    // Directed table against BLANK_CYCLES=0 instance, model checks both instances
    for (int i = 0; i < 30; i++) begin
      digit_index = vecs[i].di;
      load        = vecs[i].ld;
      value_in    = vecs[i].val;
      en_in       = vecs[i].en;
      dp_in       = vecs[i].dpm;
      lz_en       = vecs[i].lz;
      step();
      chk($sformatf("vec%0d_anode", i), 32'(anode0), 32'(vecs[i].anode));
      chk($sformatf("vec%0d_seg", i), 32'(seg0), 32'(vecs[i].seg));
      chk($sformatf("vec%0d_dp", i), 32'(dp0), 32'(vecs[i].dp));
      chk($sformatf("vec%0d_pend", i), 32'(pend0), 32'(vecs[i].pend));
    end

    // Blanking on the BLANK_CYCLES=4 instance: settle, then step 0->1
    lz_en = 1'b0;
    digit_index = 3'd0;
    repeat (8) step();
    digit_index = 3'd1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("blank_a%0d", i), 32'(anode1), 32'hFF);
    end
    step();
    chk("blank_a_end", 32'(anode1), 32'hFD);

    // Change two cycles into the window reloads the count
    digit_index = 3'd2;
    repeat (2) step();
    digit_index = 3'd3;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("reload_a%0d", i), 32'(anode1), 32'hFF);
    end
    step();
    chk("reload_a_end", 32'(anode1), 32'hF7);

    // Randomized scanning
    for (int n = 0; n < 3000; n++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 85) digit_index = digit_index + 3'd1;
      else if (r < 95) digit_index = digit_index;
      else digit_index = 3'($urandom_range(0, 7));
      load = ($urandom_range(0, 19) == 0);
      value_in = $urandom >> $urandom_range(0, 31);
      en_in = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
      dp_in = 8'($urandom);
      if ($urandom_range(0, 63) == 0) lz_en = ~lz_en;
      step();
    end

    // Load mid-frame, then asynchronous reset between clock edges
    digit_index = 3'd3;
    load = 1'b1;
    value_in = 32'h1234_5678;
    en_in = 8'hFF;
    dp_in = 8'hFF;
    step();
    chk("preload_pend", 32'(pend0), 32'd1);
    #3;
    rst = 1'b1;
    #1;
    check_dark("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    digit_index = 3'd0;

    // No fresh load after reset: a full frame scan stays dark
    for (int i = 1; i <= 10; i++) begin
      digit_index = 3'(i % 8);
      step();
      chk($sformatf("post_rst_dark%0d", i), 32'(anode0), 32'hFF);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
